// File: rtl/frame_source_arbiter.sv
// Selects between the camera and debug-pattern tagged-word streams and forwards
// whole frames from the granted source into a downstream queue.
module frame_source_arbiter #(
  parameter bit DEFAULT_SOURCE = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        src_sel,
  input  logic [16:0] cam_data,
  input  logic        cam_wr_en,
  input  logic [16:0] dbg_data,
  input  logic        dbg_wr_en,
  output logic        cam_full,
  output logic        dbg_full,
  input  logic        queue_full,
  output logic [16:0] queue_data,
  output logic        queue_wr_en,
  output logic        active_src,
  output logic        locked,
  output logic [15:0] frame_count
);

  localparam logic [16:0] TAG_FRAME_START = 17'h10000;
  localparam logic [16:0] TAG_FRAME_END   = 17'h1FFFF;

  typedef enum logic {
    ST_SYNC = 1'b0,
    ST_PASS = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        active_src_q, active_src_d;
  logic [16:0] queue_data_q, queue_data_d;
  logic        queue_wr_en_q, queue_wr_en_d;
  logic [15:0] frame_count_q, frame_count_d;

  logic        grant_wr_s;
  logic [16:0] grant_data_s;

  // Granted-source word selection and next-state / forwarding decision.
  always_comb begin
    state_d       = state_q;
    active_src_d  = active_src_q;
    queue_data_d  = queue_data_q;
    queue_wr_en_d = 1'b0;
    frame_count_d = frame_count_q;

    if (active_src_q) begin
      grant_wr_s   = dbg_wr_en;
      grant_data_s = dbg_data;
    end else begin
      grant_wr_s   = cam_wr_en;
      grant_data_s = cam_data;
    end

    case (state_q)
      ST_SYNC: begin
        // A frame start locks onto the current source; otherwise follow src_sel freely.
        if (grant_wr_s && (grant_data_s == TAG_FRAME_START)) begin
          queue_wr_en_d = 1'b1;
          queue_data_d  = grant_data_s;
          state_d       = ST_PASS;
        end else if (src_sel != active_src_q) begin
          active_src_d = src_sel;
        end else begin
          active_src_d = active_src_q;
        end
      end
      ST_PASS: begin
        if (grant_wr_s) begin
          queue_wr_en_d = 1'b1;
          queue_data_d  = grant_data_s;
          if (grant_data_s == TAG_FRAME_END) begin
            frame_count_d = frame_count_q + 16'd1;
            if (src_sel != active_src_q) begin
              active_src_d = src_sel;
              state_d      = ST_SYNC;
            end else begin
              state_d = ST_PASS;
            end
          end else begin
            frame_count_d = frame_count_q;
          end
        end else begin
          queue_wr_en_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_SYNC;
      end
    endcase
  end

  // State, grant and downstream write-port registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_SYNC;
      active_src_q  <= DEFAULT_SOURCE;
      queue_data_q  <= 17'h00000;
      queue_wr_en_q <= 1'b0;
      frame_count_q <= 16'h0000;
    end else begin
      state_q       <= state_d;
      active_src_q  <= active_src_d;
      queue_data_q  <= queue_data_d;
      queue_wr_en_q <= queue_wr_en_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Back-pressure must track queue_full in the same cycle, so it stays combinational.
  always_comb begin
    if (active_src_q) begin
      cam_full = 1'b1;
      dbg_full = queue_full;
    end else begin
      cam_full = queue_full;
      dbg_full = 1'b1;
    end
  end

  assign queue_data  = queue_data_q;
  assign queue_wr_en = queue_wr_en_q;
  assign active_src  = active_src_q;
  assign locked      = (state_q == ST_PASS);
  assign frame_count = frame_count_q;

endmodule

// File: doc/frame_source_arbiter.md
FRAME_SOURCE_ARBITER -- requirements
Module: frame_source_arbiter

Interface
REQ-001 SHALL have parameter DEFAULT_SOURCE, default 0, meaning the source granted after reset (0 = camera, 1 = debug pattern).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port src_sel, input, 1 bit: requested source (0 = camera, 1 = debug).
REQ-005 SHALL have ports cam_data (input, 17 bits) and cam_wr_en (input, 1 bit): the camera tagged-word stream.
REQ-006 SHALL have ports dbg_data (input, 17 bits) and dbg_wr_en (input, 1 bit): the debug pattern tagged-word stream.
REQ-007 SHALL have ports cam_full and dbg_full, both output, 1 bit: per-source back-pressure.
REQ-008 SHALL have port queue_full, input, 1 bit: downstream queue almost-full flag, with a margin of at least 2 entries.
REQ-009 SHALL have ports queue_data (output reg, 17 bits) and queue_wr_en (output reg, 1 bit): the downstream queue write port.
REQ-010 SHALL have port active_src, output, 1 bit: the currently granted source.
REQ-011 SHALL have port locked, output, 1 bit: 1 when the state is PASS.
REQ-012 SHALL have port frame_count, output, 16 bits: number of frames forwarded.

Function
REQ-013 SHALL recognise these tags: frame start 17'h10000; row start 17'h10001; frame end 17'h1FFFF; pixel = bit16 = 0.
REQ-014 SHALL implement exactly two states: SYNC (discard until a frame start) and PASS (forward).
REQ-015 SHALL drive the full output of the granted source equal to queue_full in both states.
REQ-016 SHALL hold the full output of the non-granted source at 1 at all times.
REQ-017 SHALL discard all words from the non-granted source.
REQ-018 In SYNC, SHALL discard granted-source words, except frame start.
REQ-019 In SYNC, a granted-source frame start SHALL be forwarded and the state SHALL move to PASS.
REQ-020 In SYNC, a src_sel that differs from active_src SHALL update active_src on the next cycle, with no frame required.
REQ-021 In PASS, SHALL forward every granted-source word with wr_en = 1 regardless of queue_full, because queue_full is advisory.
REQ-022 Forwarded words SHALL appear on queue_data/queue_wr_en exactly 1 cycle after the input cycle; queue_wr_en SHALL be 0 on every other cycle.
REQ-023 In PASS, a change of src_sel SHALL be ignored until a frame-end word is forwarded.
REQ-024 On the cycle a frame end is forwarded, if src_sel equals active_src, the state SHALL remain PASS.
REQ-025 On the cycle a frame end is forwarded, if src_sel differs from active_src, active_src SHALL take src_sel and the state SHALL move to SYNC, both on the next edge.
REQ-026 A frame start received in PASS SHALL be forwarded, with no state change.
REQ-027 frame_count SHALL increment by 1 per forwarded frame end and wrap from 16'hFFFF to 0.
REQ-028 With both sources writing in the same cycle, only the granted source's word SHALL be considered.
REQ-029 locked SHALL equal (state == PASS); active_src SHALL be a register.

Reset
REQ-030 While reset_n = 0, SHALL force: state SYNC; active_src = DEFAULT_SOURCE; queue_wr_en = 0; queue_data = 0; frame_count = 0; locked = 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no further writes; after release, forwarding SHALL resume only at the next frame start.
REQ-032 The full outputs SHALL follow REQ-015/REQ-016 during reset, so the non-granted source sees 1.

Verification
REQ-033 Reset, DEFAULT_SOURCE=0, src_sel=0, camera sends 3 pixels then 17'h10000 -> pixels dropped; 17'h10000 on queue_data 1 cycle later; locked=1; dbg_full=1.
REQ-034 In PASS on camera, set src_sel=1 mid-row, camera completes the frame with 17'h1FFFF -> all camera words forwarded; then active_src=1, locked=0, frame_count=1, cam_full=1.
REQ-035 In SYNC on debug, debug sends 17'h10001 and pixels, then 17'h10000 -> only 17'h10000 and subsequent words forwarded.
REQ-036 queue_full=1 in PASS -> active source full=1 on the same cycle; a word written that cycle is still forwarded.
REQ-037 Preload frame_count=16'hFFFF by forwarding 65535 frames, then one more frame end -> frame_count=0.
REQ-038 reset_n pulsed low mid-row -> queue_wr_en=0 immediately; next forwarded word is 17'h10000.
